dual_count_checker: RTL
=======================

// Module: dual_count_checker
// PURPOSE
//  Consumer/checker for the dual 64-bit counter interface (Slt, En, Output0, Output1).
//  Samples the same control inputs as the counter and its two count outputs.
//  Predicts each count one cycle ahead and flags every step or hold violation.
//  Sits beside the counter in bench and debug builds; reports pass/fail over a set compare window.
// PARAMETERS
//  WIDTH    64    count width, Output0/Output1 and LastBad
//  STEP0    1     increment of Output0 per enabled cycle
//  STEP1    1     increment of Output1 per enabled cycle
//  NCHK     1000  compare cycles per run (>=1)
// PORTS
//  Clk      in   1      rising-edge clock
//  Reset    in   1      asynchronous, active-low reset
//  Start    in   1      1-cycle pulse: begin/restart a run
//  Slt      in   1      counter select: 0 -> Output0, 1 -> Output1
//  En       in   1      counter enable
//  Output0  in   WIDTH  counter channel 0 value
//  Output1  in   WIDTH  counter channel 1 value
//  Busy     out  1      run in progress (SYNC or CHECK)
//  Done     out  1      run finished; held until next Start
//  Pass     out  1      valid when Done: 1 iff ErrCnt==0
//  ErrPulse out  1      1-cycle pulse per mismatch cycle
//  ErrChan  out  1      channel of the latest mismatch
//  ErrCnt   out  8      mismatch cycles, saturating at 255
//  LastBad  out  WIDTH  observed value of the latest mismatching channel
// BEHAVIOUR
//  Reset low (async): state=IDLE. All outputs 0. Delay regs and window counter 0.
//  Counter contract: En/Slt sampled in cycle n take effect on Output0/1 in cycle n+1.
//  FSM IDLE -> SYNC -> CHECK -> DONE -> (Start) SYNC.
//   IDLE:  wait for Start.
//   SYNC:  one cycle. Capture O0_d, O1_d, En_d, Slt_d from inputs. Clear ErrCnt, Done, Pass, ErrChan, LastBad.
//   CHECK: every cycle compare the inputs against the prediction from the delayed regs, then reload the delayed regs.
//          The window counter counts 0..NCHK-1; after NCHK compares go to DONE.
//   DONE:  Done=1. Pass=(ErrCnt==0). Busy=0.
//  Busy=1 in SYNC and CHECK.
//  Prediction, all arithmetic mod 2^WIDTH:
//   En_d=0:         exp0=O0_d,         exp1=O1_d
//   En_d=1,Slt_d=0: exp0=O0_d+STEP0,   exp1=O1_d
//   En_d=1,Slt_d=1: exp0=O0_d,         exp1=O1_d+STEP1
//  Wrap: all-ones + 1 -> 0 is correct, not an error.
//  Mismatch cycle (either channel differs):
//   ErrPulse=1 the next cycle.
//   ErrCnt+1, saturating at 255.
//   ErrChan and LastBad latched. If both channels are wrong, report channel 0.
//   Only one count per cycle, even if both channels mismatch.
//  Resync after an error: the delayed regs always take the observed values, never the expected ones.
//   A single glitch therefore gives at most 2 errors and does not cascade.
//  Start in any state restarts at SYNC. Start in CHECK aborts the run with no Done.
//  Start in SYNC re-enters SYNC.
//  Inputs are ignored in IDLE and DONE.
//  Outputs are registered; ErrPulse latency is 1 cycle from the offending sample.
//  Reset mid-run: immediate return to the reset values above. No partial Done.
// TESTING
//  T1 reset: Reset=0 mid-CHECK -> all outputs 0 in the same cycle, IDLE; Reset=1 -> stays IDLE until Start.
//  T2 clean run, NCHK=8: Start; counter runs En=1,Slt=0 from Output0=5 -> Done=1, Pass=1, ErrCnt=0 after 1+8 cycles.
//  T3 wrap: Output1=64'hFFFF_FFFF_FFFF_FFFF, En=1,Slt=1, next cycle Output1=0 -> no ErrPulse, Pass=1.
//  T4 hold violation: En=0, Output0 changes 7->8 -> ErrPulse once, ErrChan=0, LastBad=8, ErrCnt=1; later cycles clean.
//  T5 saturation: Output0 forced wrong for 300 compare cycles, NCHK=400 -> ErrCnt=255, Pass=0 at Done.
//  T6 restart: Start pulsed at window cycle 3 -> Busy stays 1, ErrCnt cleared, full NCHK window rerun, single Done.

Source files
------------

// File: rtl/dual_count_checker.sv
// rtl/dual_count_checker.sv - predicts the dual counter one cycle ahead and flags step/hold violations
module dual_count_checker #(
    parameter int WIDTH = 64,
    parameter int STEP0 = 1,
    parameter int STEP1 = 1,
    parameter int NCHK  = 1000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_slt,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_output0,
    input  logic [WIDTH-1:0] i_output1,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_err_pulse,
    output logic             o_err_chan,
    output logic [7:0]       o_err_cnt,
    output logic [WIDTH-1:0] o_last_bad
);

    localparam int             CW       = (NCHK > 1) ? $clog2(NCHK) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(NCHK - 1);

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_CHECK, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_o0_d, r_o1_d;
    logic             r_en_d, r_slt_d;
    logic [CW-1:0]    r_win;
    logic             r_busy, r_done, r_pass, r_err_pulse, r_err_chan;
    logic [7:0]       r_err_cnt;
    logic [WIDTH-1:0] r_last_bad;

    logic [WIDTH-1:0] w_exp0, w_exp1;
    logic             w_bad0, w_bad1, w_bad;
    logic [7:0]       w_cnt_next;

    assign w_exp0     = r_o0_d + ((r_en_d && !r_slt_d) ? WIDTH'(STEP0) : '0);
    assign w_exp1     = r_o1_d + ((r_en_d &&  r_slt_d) ? WIDTH'(STEP1) : '0);
    assign w_bad0     = (i_output0 != w_exp0);
    assign w_bad1     = (i_output1 != w_exp1);
    assign w_bad      = w_bad0 | w_bad1;
    assign w_cnt_next = (w_bad && (r_err_cnt != 8'hFF)) ? r_err_cnt + 8'd1 : r_err_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_o0_d      <= '0;
            r_o1_d      <= '0;
            r_en_d      <= 1'b0;
            r_slt_d     <= 1'b0;
            r_win       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_chan  <= 1'b0;
            r_err_cnt   <= 8'd0;
            r_last_bad  <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (i_start) begin
                // Start wins in every state, so a run in CHECK is abandoned without Done
                r_state    <= S_SYNC;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_pass     <= 1'b0;
                r_err_chan <= 1'b0;
                r_err_cnt  <= 8'd0;
                r_last_bad <= '0;
                r_win      <= '0;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_SYNC: begin
                        r_o0_d  <= i_output0;
                        r_o1_d  <= i_output1;
                        r_en_d  <= i_en;
                        r_slt_d <= i_slt;
                        r_win   <= '0;
                        r_state <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (w_bad) begin
                            r_err_pulse <= 1'b1;
                            r_err_cnt   <= w_cnt_next;
                            r_err_chan  <= !w_bad0;
                            r_last_bad  <= w_bad0 ? i_output0 : i_output1;
                        end
                        // Reload from observed values so one glitch cannot cascade
                        r_o0_d  <= i_output0;
                        r_o1_d  <= i_output1;
                        r_en_d  <= i_en;
                        r_slt_d <= i_slt;
                        if (r_win == LAST_IDX) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_cnt_next == 8'd0);
                        end else begin
                            r_win <= r_win + 1'b1;
                        end
                    end
                    S_DONE: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_pulse = r_err_pulse;
    assign o_err_chan  = r_err_chan;
    assign o_err_cnt   = r_err_cnt;
    assign o_last_bad  = r_last_bad;

endmodule
